// File: rtl/render_pkg.sv
// Shared tag types and default stage latencies for the ray-tracing pixel pipeline.
package render_pkg;
  localparam int HCOUNT_W      = 11;
  localparam int VCOUNT_W      = 10;
  localparam int SELECT_W      = 2;
  localparam int RFP_LATENCY   = 24;
  localparam int SHADE_LATENCY = 64;

  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic [SELECT_W-1:0] select_objs;
    logic                miss;
  } pixel_tag_t;
endpackage

// File: rtl/render_sideband_pipe_if.sv
// Valid/ready stream carrying CHANNELS tag lanes of WIDTH bits each.
interface render_sideband_pipe_if
  import render_pkg::*;
#(
  parameter int WIDTH    = HCOUNT_W,
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0][WIDTH-1:0] tdata;
  logic                           tvalid;
  logic                           tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/render_sideband_pipe_stage.sv
// One sideband stage: valid flag plus tag register that only captures valid items.
module sideband_stage
  import render_pkg::*;
#(
  parameter int WIDTH    = HCOUNT_W,
  parameter int CHANNELS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           load,
  input  logic                           d_vld,
  input  logic [CHANNELS-1:0][WIDTH-1:0] d_data,
  output logic                           q_vld,
  output logic [CHANNELS-1:0][WIDTH-1:0] q_data
);
  // Data holds across bubbles so the tag bus does not toggle on empty slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vld  <= 1'b0;
      q_data <= '0;
    end else if (clear) begin
      q_vld <= 1'b0;
    end else if (load) begin
      q_vld <= d_vld;
      if (d_vld) q_data <= d_data;
    end
  end
endmodule

// File: rtl/render_sideband_pipe.sv
// Backpressure-aware sideband delay line that keeps pixel tags aligned with a
// fixed-latency datapath; optional bubble collapsing, fill level and alignment check.
module render_sideband_pipe
  import render_pkg::*;
#(
  parameter int LATENCY         = SHADE_LATENCY,
  parameter int WIDTH           = HCOUNT_W,
  parameter int CHANNELS        = 2,
  parameter int BUBBLE_COLLAPSE = 0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           clear,
  render_sideband_pipe_if.slave          s_axis,
  render_sideband_pipe_if.master         m_axis,
  input  logic                           ref_tvalid,
  output logic [$clog2(LATENCY+1)-1:0]   occupancy,
  output logic                           align_error
);
  localparam int OCC_W = $clog2(LATENCY+1);
  typedef logic [CHANNELS-1:0][WIDTH-1:0] tag_t;

  logic [LATENCY-1:0] vld_p;
  logic [LATENCY-1:0] vld_d;
  logic [LATENCY-1:0] load;
  tag_t               data_p [LATENCY];
  tag_t               data_d [LATENCY];
  logic               s_ready;
  logic               in_xfer;
  logic               out_xfer;

  assign in_xfer       = s_axis.tvalid & s_ready;
  assign out_xfer      = vld_p[LATENCY-1] & m_axis.tready;
  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = vld_p[LATENCY-1];
  assign m_axis.tdata  = data_p[LATENCY-1];

  generate
    if (BUBBLE_COLLAPSE == 0) begin : g_lockstep
      logic advance;
      assign advance = m_axis.tready | ~vld_p[LATENCY-1];
      assign load    = {LATENCY{advance}};
      assign s_ready = advance & ~clear & ~areset;
    end else begin : g_collapse
      // A stage may load when it is empty or its occupant moves on this cycle.
      logic [LATENCY-1:0] rdy;
      always_comb begin
        rdy[LATENCY-1] = m_axis.tready | ~vld_p[LATENCY-1];
        for (int i = LATENCY - 2; i >= 0; i--) rdy[i] = ~vld_p[i] | rdy[i+1];
      end
      assign load    = rdy;
      assign s_ready = rdy[0] & ~clear & ~areset;
    end
  endgenerate

  // Stage chain: stage 0 takes the accepted input, stage i takes stage i-1.
  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign vld_d[0]  = in_xfer;
      assign data_d[0] = s_axis.tdata;
    end else begin : g_body
      assign vld_d[i]  = vld_p[i-1];
      assign data_d[i] = data_p[i-1];
    end
    sideband_stage #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_stage (
      .clk    (aclk),
      .rst    (areset),
      .clear  (clear),
      .load   (load[i]),
      .d_vld  (vld_d[i]),
      .d_data (data_d[i]),
      .q_vld  (vld_p[i]),
      .q_data (data_p[i])
    );
  end

  // Fill level and sticky misalignment flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      occupancy   <= '0;
      align_error <= 1'b0;
    end else if (clear) begin
      occupancy   <= '0;
      align_error <= 1'b0;
    end else begin
      if (in_xfer & ~out_xfer)      occupancy <= occupancy + OCC_W'(1);
      else if (out_xfer & ~in_xfer) occupancy <= occupancy - OCC_W'(1);
      if (m_axis.tvalid != ref_tvalid) align_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_render_sideband_pipe.sv
// Bench for render_sideband_pipe: lockstep and bubble-collapse instances driven
// by shared stimulus, each tracked by an item-position model of the pipe.
module tb_render_sideband_pipe;
  localparam int LAT = 4;
  localparam int W   = 11;
  localparam int CH  = 2;
  typedef logic [CH-1:0][W-1:0] tag_t;

  logic aclk     = 1'b0;
  logic areset   = 1'b1;
  logic clear    = 1'b0;
  logic s_tvalid = 1'b0;
  logic m_tready = 1'b1;
  tag_t s_tdata  = '0;
  int   ref_sel  = 0;
  logic ref_rnd  = 1'b0;

  logic       dly  [2];
  logic       refv [2];
  logic       mv   [2];
  tag_t       md   [2];
  logic       sr   [2];
  logic [2:0] occ  [2];
  logic       aerr [2];

  int tests = 0;
  int fails = 0;

  // Model: each DUT holds an ordered list of items (head first) with stage positions.
  int   pos [2][LAT];
  tag_t dat [2][LAT];
  int   cnt [2];
  bit   alg [2];

  always #5 aclk = ~aclk;

  render_sideband_pipe_if #(.WIDTH(W), .CHANNELS(CH)) s0 ();
  render_sideband_pipe_if #(.WIDTH(W), .CHANNELS(CH)) m0 ();
  render_sideband_pipe_if #(.WIDTH(W), .CHANNELS(CH)) s1 ();
  render_sideband_pipe_if #(.WIDTH(W), .CHANNELS(CH)) m1 ();

  assign s0.tvalid = s_tvalid;
  assign s0.tdata  = s_tdata;
  assign m0.tready = m_tready;
  assign s1.tvalid = s_tvalid;
  assign s1.tdata  = s_tdata;
  assign m1.tready = m_tready;

  assign mv[0] = m0.tvalid;
  assign md[0] = m0.tdata;
  assign sr[0] = s0.tready;
  assign mv[1] = m1.tvalid;
  assign md[1] = m1.tdata;
  assign sr[1] = s1.tready;

  assign refv[0] = (ref_sel == 0) ? m0.tvalid : (ref_sel == 1) ? dly[0] : ref_rnd;
  assign refv[1] = (ref_sel == 0) ? m1.tvalid : (ref_sel == 1) ? dly[1] : ref_rnd;

  always @(posedge aclk) begin
    dly[0] <= m0.tvalid;
    dly[1] <= m1.tvalid;
  end

  render_sideband_pipe #(.LATENCY(LAT), .WIDTH(W), .CHANNELS(CH), .BUBBLE_COLLAPSE(0)) dut0 (
    .aclk(aclk), .areset(areset), .clear(clear), .s_axis(s0), .m_axis(m0),
    .ref_tvalid(refv[0]), .occupancy(occ[0]), .align_error(aerr[0]));

  render_sideband_pipe #(.LATENCY(LAT), .WIDTH(W), .CHANNELS(CH), .BUBBLE_COLLAPSE(1)) dut1 (
    .aclk(aclk), .areset(areset), .clear(clear), .s_axis(s1), .m_axis(m1),
    .ref_tvalid(refv[1]), .occupancy(occ[1]), .align_error(aerr[1]));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    for (int d = 0; d < 2; d++) begin
      int   np [LAT+1];
      tag_t nd [LAT+1];
      int   nc, ahead, p;
      bit   ev, er, adv, leave;
      ev = (cnt[d] > 0) && (pos[d][0] == LAT - 1);
      if (areset) begin
        check($sformatf("d%0d rst tvalid", d), 64'(mv[d]), 64'(0));
        check($sformatf("d%0d rst occ", d), 64'(occ[d]), 64'(0));
        check($sformatf("d%0d rst tready", d), 64'(sr[d]), 64'(0));
        check($sformatf("d%0d rst align", d), 64'(aerr[d]), 64'(0));
        cnt[d] = 0;
        alg[d] = 0;
      end else begin
        leave = ev && m_tready;
        adv   = !ev || m_tready;
        nc    = 0;
        ahead = LAT;
        for (int i = 0; i < cnt[d]; i++) begin
          if (!(i == 0 && leave)) begin
            if (d == 0) p = adv ? pos[d][i] + 1 : pos[d][i];
            else begin
              p = pos[d][i] + 1;
              if (p > ahead - 1) p = ahead - 1;
            end
            np[nc] = p;
            nd[nc] = dat[d][i];
            ahead  = p;
            nc++;
          end
        end
        er = !clear && ((d == 0) ? adv : (nc == 0 || np[nc-1] > 0));
        check($sformatf("d%0d tvalid", d), 64'(mv[d]), 64'(ev));
        if (ev) check($sformatf("d%0d tdata", d), 64'(md[d]), 64'(dat[d][0]));
        check($sformatf("d%0d occupancy", d), 64'(occ[d]), 64'(cnt[d]));
        check($sformatf("d%0d align", d), 64'(aerr[d]), 64'(alg[d]));
        check($sformatf("d%0d tready", d), 64'(sr[d]), 64'(er));
        if (clear) begin
          cnt[d] = 0;
          alg[d] = 0;
        end else begin
          if (s_tvalid && er) begin
            np[nc] = 0;
            nd[nc] = s_tdata;
            nc++;
          end
          for (int i = 0; i < nc && i < LAT; i++) begin
            pos[d][i] = np[i];
            dat[d][i] = nd[i];
          end
          cnt[d] = nc;
          if (ev != refv[d]) alg[d] = 1;
        end
      end
    end
  end

  task automatic do_clear();
    @(posedge aclk); #1;
    clear    = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(posedge aclk); #1;
    clear = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("reset tvalid", 64'(mv[0]), 64'(0));
    check("reset occ", 64'(occ[0]), 64'(0));
    check("reset align", 64'(aerr[0]), 64'(0));
    check("post-reset tready0", 64'(sr[0]), 64'(1));
    check("post-reset tready1", 64'(sr[1]), 64'(1));

    // Streaming 0..9 / 100..109 with downstream always ready.
    for (int k = 0; k < 14; k++) begin
      @(posedge aclk); #1;
      s_tvalid   = (k < 10);
      s_tdata[0] = 11'(k);
      s_tdata[1] = 11'(100 + k);
      @(negedge aclk);
      if (k == 4) begin
        check("stream first valid", 64'(mv[0]), 64'(1));
        check("stream first ch0", 64'(md[0][0]), 64'(0));
        check("stream first ch1", 64'(md[0][1]), 64'(100));
        check("stream first ch0 collapse", 64'(md[1][0]), 64'(0));
      end
      if (k == 8) begin
        check("stream occ", 64'(occ[0]), 64'(4));
        check("stream ch0 k8", 64'(md[0][0]), 64'(4));
      end
    end

    // Lockstep stall: A, bubble, B; stall while A is at the output.
    do_clear();
    for (int c = 0; c < 10; c++) begin
      @(posedge aclk); #1;
      s_tvalid   = (c == 0 || c == 2);
      s_tdata[0] = (c == 0) ? 11'd11 : 11'd22;
      s_tdata[1] = 11'd0;
      m_tready   = !(c >= 4 && c <= 6);
      @(negedge aclk);
      if (c >= 4 && c <= 6) begin
        check("stall valid", 64'(mv[0]), 64'(1));
        check("stall data", 64'(md[0][0]), 64'(11));
        check("stall tready", 64'(sr[0]), 64'(0));
      end
      if (c == 7) check("release A", 64'(md[0][0]), 64'(11));
      if (c == 8) check("release bubble", 64'(mv[0]), 64'(0));
      if (c == 9) begin
        check("release B valid", 64'(mv[0]), 64'(1));
        check("release B data", 64'(md[0][0]), 64'(22));
      end
    end

    // Collapse: A _ B _ C D into a stalled pipe, then drain back to back.
    do_clear();
    for (int c = 0; c < 11; c++) begin
      @(posedge aclk); #1;
      m_tready   = (c >= 7);
      s_tvalid   = (c == 0 || c == 2 || c == 4 || c == 5);
      s_tdata[0] = (c == 0) ? 11'd1 : (c == 2) ? 11'd2 : (c == 4) ? 11'd3 : 11'd4;
      s_tdata[1] = 11'd0;
      @(negedge aclk);
      if (c == 5) check("collapse ready at 3", 64'(sr[1]), 64'(1));
      if (c == 6) begin
        check("collapse occ full", 64'(occ[1]), 64'(4));
        check("collapse ready full", 64'(sr[1]), 64'(0));
      end
      if (c >= 7) begin
        check("collapse drain valid", 64'(mv[1]), 64'(1));
        check("collapse drain data", 64'(md[1][0]), 64'(c - 6));
      end
    end

    // Alignment: reference valid one cycle late.
    do_clear();
    @(negedge aclk);
    check("align after clear", 64'(aerr[0]), 64'(0));
    ref_sel = 1;
    for (int k = 0; k < 14; k++) begin
      @(posedge aclk); #1;
      s_tvalid   = (k < 6);
      s_tdata[0] = 11'(50 + k);
    end
    @(negedge aclk);
    check("align set", 64'(aerr[0]), 64'(1));
    ref_sel = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("align held", 64'(aerr[0]), 64'(1));
    do_clear();
    @(negedge aclk);
    check("align cleared", 64'(aerr[0]), 64'(0));

    // Clear mid-stream with a same-cycle input.
    for (int k = 0; k < 6; k++) begin
      @(posedge aclk); #1;
      s_tvalid   = 1'b1;
      s_tdata[0] = 11'(200 + k);
    end
    @(posedge aclk); #1;
    clear      = 1'b1;
    s_tdata[0] = 11'd999;
    @(negedge aclk);
    check("clear tready0", 64'(sr[0]), 64'(0));
    check("clear tready1", 64'(sr[1]), 64'(0));
    @(posedge aclk); #1;
    clear    = 1'b0;
    s_tvalid = 1'b0;
    @(negedge aclk);
    check("clear occ0", 64'(occ[0]), 64'(0));
    check("clear occ1", 64'(occ[1]), 64'(0));
    check("clear tvalid0", 64'(mv[0]), 64'(0));
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      check("cleared item absent", 64'(mv[0]), 64'(0));
    end

    // Fill the pipe, then pulse areset between edges.
    @(posedge aclk); #1;
    m_tready = 1'b0;
    ref_sel  = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge aclk); #1;
      s_tvalid   = 1'b1;
      s_tdata[0] = 11'(300 + k);
    end
    @(negedge aclk);
    check("full occ", 64'(occ[0]), 64'(4));
    check("full align", 64'(aerr[0]), 64'(1));
    @(posedge aclk); #2;
    areset = 1'b1;
    #2;
    check("async tvalid0", 64'(mv[0]), 64'(0));
    check("async tvalid1", 64'(mv[1]), 64'(0));
    check("async occ0", 64'(occ[0]), 64'(0));
    check("async align0", 64'(aerr[0]), 64'(0));
    @(posedge aclk); #1;
    areset   = 1'b0;
    ref_sel  = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(negedge aclk);
    check("release tready0", 64'(sr[0]), 64'(1));
    check("release tready1", 64'(sr[1]), 64'(1));

    // Randomised traffic, backpressure, reference phase and occasional clears.
    for (int k = 0; k < 1500; k++) begin
      @(posedge aclk); #1;
      s_tvalid   = ($urandom_range(0, 3) != 0);
      s_tdata[0] = 11'($urandom);
      s_tdata[1] = 11'($urandom);
      m_tready   = ($urandom_range(0, 2) != 0);
      ref_sel    = int'($urandom_range(0, 2));
      ref_rnd    = 1'($urandom_range(0, 1));
      clear      = ($urandom_range(0, 40) == 0);
    end
    @(posedge aclk); #1;
    clear = 1'b0;
    @(negedge aclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/render_sideband_pipe.md
# render_sideband_pipe

Parametrised, backpressure-aware sideband delay line for the ray-tracing pixel pipeline. It carries per-pixel tags (hcount, vcount, hit/miss flag, object-select bits) alongside a fixed-latency datapath such as ray generation, object check or shading, so the tags emerge on the same cycle as the matching pixel. Unlike the fixed single-channel delay pipes it replaces, it honours `m_axis_tready`, optionally squeezes out bubbles, reports its fill level, and flags any loss of alignment with the parallel datapath.

## Interface
Parameters:
- `LATENCY`, 64: stage count; ≥1; cycles from input transfer to output with no stalls.
- `WIDTH`, 11: bits per channel.
- `CHANNELS`, 2: independent tag channels carried in lockstep.
- `BUBBLE_COLLAPSE`, 0: 0 = whole pipe stalls together; 1 = stages fill independently.

Ports:
- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush.
- `s_axis_tdata`  in  CHANNELS×WIDTH  packed `[CHANNELS-1:0][WIDTH-1:0]` input tags.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `m_axis_tdata`  out  CHANNELS×WIDTH  delayed tags.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream ready.
- `ref_tvalid`  in  1  output valid of the parallel datapath being matched.
- `occupancy`  out  $clog2(LATENCY+1)  number of valid stages.
- `align_error`  out  1  sticky misalignment flag.

## Operation
- Each stage `i` holds `data[i]` and `v[i]`. Stage `LATENCY-1` drives `m_axis_*`. An input transfer is `s_axis_tvalid & s_axis_tready`. An output transfer is `m_axis_tvalid & m_axis_tready`.
- **Mode 0 (`BUBBLE_COLLAPSE=0`):**
  - `advance = m_axis_tready | ~v[LATENCY-1]`.
  - When `advance` is high, every stage shifts by one. `v[0]` loads the input-transfer bit.
  - `s_axis_tready = advance`.
  - Bubbles are preserved, so spacing in equals spacing out.
- **Mode 1 (`BUBBLE_COLLAPSE=1`):**
  - `rdy[LATENCY-1] = m_axis_tready | ~v[LATENCY-1]`.
  - `rdy[i] = ~v[i] | rdy[i+1]`.
  - Stage `i` loads from stage `i-1` when `rdy[i]` is high.
  - `s_axis_tready = rdy[0]`. It deasserts only when all `LATENCY` stages are valid and downstream is stalled.
- A data register loads only when its stage loads a valid item. Otherwise it holds its value, so there is no toggle on bubbles.
- **`occupancy`:**
  - +1 on an input transfer only.
  - −1 on an output transfer only.
  - Unchanged when both or neither occur.
  - Never exceeds `LATENCY`.
- **`align_error`:**
  - Set in any cycle where `m_axis_tvalid != ref_tvalid`, outside reset and clear.
  - Held until `clear` or `areset`.
- **`clear`:**
  - All `v` go to 0 and `occupancy` goes to 0 on the next edge.
  - `align_error` is cleared.
  - `s_axis_tready` is 0 in the `clear` cycle, so a same-cycle input is not accepted and is dropped.
  - An output transfer in the same cycle still completes. `clear` wins over all other updates.
- **Reset (`areset` high):**
  - Takes effect immediately, with no clock needed.
  - All `v` = 0, all data = 0, `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `occupancy` = 0, `align_error` = 0.
  - `s_axis_tready` = 0 while reset is high, and 1 from the first cycle after release.

## Timing
- **Latency:** an item accepted at edge t is presented on `m_axis` in cycle t+LATENCY, provided there are no stalls. Each stall cycle seen by the item adds one cycle.
- **Registered outputs:** `m_axis_tdata`, `m_axis_tvalid`, `occupancy` and `align_error` come straight from flops.
- **Combinational ready path:** `s_axis_tready` depends on `m_axis_tready`.
  - Mode 0: through one gate.
  - Mode 1: through the `rdy` chain, up to LATENCY deep. Mode 1 is intended for LATENCY ≤ 32 at the pixel clock.
- **Full condition:** with the pipe full and `m_axis_tready = 1`, the pipe accepts and emits in the same cycle, giving sustained throughput of 1 item/cycle.
- **Empty condition:** `m_axis_tvalid = 0` and `m_axis_tready` is ignored.
- **Output stability:** while `m_axis_tvalid & ~m_axis_tready`, `m_axis_tdata` and `m_axis_tvalid` are held stable.

## Structure
- **Package `render_pkg`:**
  - `HCOUNT_W = 11`, `VCOUNT_W = 10`, `SELECT_W = 2`.
  - Typedef `pixel_tag_t` = {hcount, vcount, select_objs, miss}.
  - Default pipeline latencies: `RFP_LATENCY = 24`, `SHADE_LATENCY = 64`.
- **Sub-module `sideband_stage`:** one valid/data register with load enable, clear and async reset, instantiated LATENCY times by a generate loop.
- **Top level:** holds the ready logic (per mode), the occupancy counter and the alignment checker.

## Test plan
All scenarios use `LATENCY=4`, `WIDTH=11`, `CHANNELS=2` unless noted.
1. **Streaming, mode 0:** `s_axis_tvalid` held at 1 with data 0..9 on channel 0 and 100..109 on channel 1, `m_axis_tready = 1` → first output (0, 100) appears 4 cycles after the first accept, then one item per cycle in order; `occupancy` holds at 4.
2. **Stall, mode 0:** input A, bubble, B, then `m_axis_tready = 0` once A reaches the output → all stages frozen, `s_axis_tready = 0`, A stays stable; release → A, bubble, B emerge with the original spacing.
3. **Collapse, mode 1:** inputs A, _, B, _, C, D with `m_axis_tready = 0` → `occupancy` reaches 4; `s_axis_tready` drops only at 4; release → A, B, C, D on consecutive cycles.
4. **Alignment:** `ref_tvalid` driven one cycle late relative to `m_axis_tvalid` → `align_error = 1` on the edge after the first mismatch, held after the streams realign; `clear` → 0.
5. **Clear:** `clear` mid-stream with `s_axis_tvalid = 1` → `s_axis_tready = 0` that cycle; next cycle `occupancy = 0`, `m_axis_tvalid = 0`; the input item never appears at the output.
6. **Async reset:** `areset` pulsed between clock edges with the pipe full → `m_axis_tvalid`, `occupancy` and `align_error` go to 0 before the next edge; `s_axis_tready` returns to 1 the cycle after release.
